bf8b_sequencer: RTL and testbench

Top-level control sequencer for the bf8b core. Runs a fetch -> decode -> dispatch loop: fetches 8-bit instructions from program memory, drives the instruction decoder through its en/ready handshake, and dispatches each decoded instruction to one of three execution units (memory, ALU, I/O) over req/ack handshakes. Owns the program counter, conditional jumps, halt detection and the execution-timeout error.

---
 rtl/bf8b_sequencer.sv | 142 ++++++++++++++
 tb/tb_bf8b_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf8b_sequencer.sv
// bf8b_sequencer: fetch -> decode -> dispatch control loop for the bf8b core.
// Owns the program counter, conditional jumps, halt detection and the
// execution-timeout error. Every output is a flop; the outputs are loaded
// from the next-state value, so each output changes on the same edge as the
// state that it reflects.
module bf8b_sequencer #(
    parameter int         PC_W         = 6,
    parameter int         EXEC_TIMEOUT = 16,
    parameter logic [7:0] HALT_OP      = 8'hFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            zero_flag,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic            dec_en,
    output logic [7:0]      dec_inst,
    input  logic [1:0]      dec_type,
    input  logic            dec_srcdst,
    input  logic [5:0]      dec_addr,
    input  logic            dec_ready,
    output logic            mem_req,
    output logic            alu_req,
    output logic            io_req,
    input  logic            mem_ack,
    input  logic            alu_ack,
    input  logic            io_ack,
    output logic            exec_srcdst,
    output logic [5:0]      exec_addr,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_DECODE   = 3'd2;
    localparam logic [2:0] S_DISPATCH = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    localparam int CNT_W = (EXEC_TIMEOUT > 2) ? $clog2(EXEC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((EXEC_TIMEOUT > 0) ? EXEC_TIMEOUT - 1 : 0);

    logic [2:0]       state, state_nxt;
    logic [1:0]       dtype;      // latched decoder inst_type
    logic             first_dec;  // high in the first DECODE cycle
    logic [CNT_W-1:0] cnt;        // cycles spent in WAIT_EXEC
    logic             ack_hit;
    logic             tmo;
    logic             dec_take;

    // The fetch address is the program counter itself.
    assign imem_addr = pc;

    // Next-state selection; only the ack that matches the pending request counts.
    always_comb begin
        ack_hit   = (dtype == 2'b01 && mem_ack) ||
                    (dtype == 2'b10 && alu_ack) ||
                    (dtype == 2'b11 && io_ack);
        tmo       = (EXEC_TIMEOUT != 0) && (cnt == CNT_LAST);
        // A ready seen in the first DECODE cycle may be left over from the
        // previous instruction, so it is not trusted.
        dec_take  = !first_dec && dec_ready;
        state_nxt = state;
        case (state)
            S_IDLE:     if (run) state_nxt = S_FETCH;
            S_FETCH:    if (imem_ack)
                            state_nxt = (imem_data == HALT_OP) ? S_HALT : S_DECODE;
            S_DECODE:   if (dec_take) state_nxt = S_DISPATCH;
            S_DISPATCH: state_nxt = (dtype == 2'b00) ? S_FETCH : S_WAIT;
            S_WAIT:     if (ack_hit) state_nxt = S_FETCH;
                        else if (tmo) state_nxt = S_HALT;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            dec_inst    <= '0;
            dtype       <= '0;
            first_dec   <= 1'b1;
            cnt         <= '0;
            imem_req    <= 1'b0;
            dec_en      <= 1'b0;
            mem_req     <= 1'b0;
            alu_req     <= 1'b0;
            io_req      <= 1'b0;
            exec_srcdst <= 1'b0;
            exec_addr   <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state     <= state_nxt;
            first_dec <= (state != S_DECODE);

            imem_req  <= (state_nxt == S_FETCH);
            dec_en    <= (state_nxt == S_DECODE);
            mem_req   <= (state_nxt == S_WAIT) && (dtype == 2'b01);
            alu_req   <= (state_nxt == S_WAIT) && (dtype == 2'b10);
            io_req    <= (state_nxt == S_WAIT) && (dtype == 2'b11);
            busy      <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
            halted    <= (state_nxt == S_HALT);

            if (state == S_FETCH && imem_ack)
                dec_inst <= imem_data;

            if (state == S_DECODE && dec_take) begin
                dtype       <= dec_type;
                exec_srcdst <= dec_srcdst;
                exec_addr   <= dec_addr;
            end

            // Jump target comes from the address latched at decode, which is
            // the decoder's addr for this instruction.
            if (state == S_DISPATCH) begin
                cnt <= '0;
                if (dtype == 2'b00)
                    pc <= zero_flag ? PC_W'(exec_addr) : pc + PC_W'(1);
            end

            if (state == S_WAIT) begin
                cnt <= cnt + CNT_W'(1);
                if (ack_hit)
                    pc <= pc + PC_W'(1);
                else if (tmo)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bf8b_sequencer.sv
// tb_bf8b_sequencer: drives bf8b_sequencer against a behavioural program
// memory, decoder and execution units, and checks it against an
// instruction-level model of the program (pc, dispatches, halt).
module tb_bf8b_sequencer;

    localparam int PC_W = 6;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst, run, zero_flag;
    logic imem_req, imem_ack;
    logic [PC_W-1:0] imem_addr, pc;
    logic [7:0] imem_data, dec_inst;
    logic dec_en, dec_srcdst, dec_ready;
    logic [1:0] dec_type;
    logic [5:0] dec_addr, exec_addr;
    logic mem_req, alu_req, io_req, mem_ack, alu_ack, io_ack;
    logic exec_srcdst, busy, halted, err;

    always #5 clk = ~clk;

    bf8b_sequencer #(.PC_W(PC_W), .EXEC_TIMEOUT(TMO), .HALT_OP(8'hFF)) dut (
        .clk(clk), .rst(rst), .run(run), .zero_flag(zero_flag),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .dec_en(dec_en), .dec_inst(dec_inst),
        .dec_type(dec_type), .dec_srcdst(dec_srcdst), .dec_addr(dec_addr),
        .dec_ready(dec_ready), .mem_req(mem_req), .alu_req(alu_req),
        .io_req(io_req), .mem_ack(mem_ack), .alu_ack(alu_ack), .io_ack(io_ack),
        .exec_srcdst(exec_srcdst), .exec_addr(exec_addr), .pc(pc),
        .busy(busy), .halted(halted), .err(err)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] imem [64];

    // environment knobs and state
    bit rnd_lat, stray, stale, manual;
    int fcnt, mlat, dcnt, dtgt, ecnt, elat;

    function automatic logic [34:0] outs();
        return {imem_req, imem_addr, dec_en, dec_inst, mem_req, alu_req, io_req,
                exec_srcdst, exec_addr, pc, busy, halted, err};
    endfunction

    // One clock: advance past the edge, then drive the environment's response
    // for the new cycle from the freshly registered outputs.
    task automatic cyc();
        @(posedge clk); #1;
        imem_data = imem[imem_addr];
        if (imem_req) begin
            imem_ack = (fcnt == mlat);
            fcnt++;
            if (imem_ack) mlat = rnd_lat ? int'($urandom_range(0, 2)) : 0;
        end else begin
            fcnt = 0;
            imem_ack = stray && ($urandom_range(0, 3) == 0);
        end
        if (dec_en) begin
            if (dcnt == 0) begin
                if (!stale) dec_ready = 1'b0;
                dtgt = rnd_lat ? int'($urandom_range(0, 2)) : 0;
            end else begin
                dec_type   = dec_inst[7:6];
                dec_srcdst = dec_inst[5];
                dec_addr   = dec_inst[5:0];
                dec_ready  = (dcnt >= 1 + dtgt);
            end
            dcnt++;
        end else begin
            dcnt = 0;
            if (!stale) dec_ready = 1'b0;
        end
        if (manual) begin
            mem_ack = 1'b0; alu_ack = 1'b0; io_ack = 1'b0;
        end else if ({io_req, alu_req, mem_req} == 3'b000) begin
            ecnt = 0;
            elat = rnd_lat ? int'($urandom_range(0, 3)) : 0;
            mem_ack = stray && ($urandom_range(0, 3) == 0);
            alu_ack = stray && ($urandom_range(0, 3) == 0);
            io_ack  = stray && ($urandom_range(0, 3) == 0);
        end else begin
            mem_ack = mem_req ? (ecnt == elat) : (stray && ($urandom_range(0, 2) == 0));
            alu_ack = alu_req ? (ecnt == elat) : (stray && ($urandom_range(0, 2) == 0));
            io_ack  = io_req  ? (ecnt == elat) : (stray && ($urandom_range(0, 2) == 0));
            ecnt++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; dec_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic fill_halts();
        for (int i = 0; i < 64; i++) imem[i] = 8'hFF;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0;
        cyc();
        tests++;
        if (outs() !== 35'd0) $display("FAIL reset_outs: got %h expected 0", outs());
        if (outs() !== 35'd0) fails++;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            tests++;
            if (outs() !== 35'd0) begin
                fails++;
                $display("FAIL idle_outs cycle %0d: got %h expected 0", i, outs());
            end
        end
    endtask

    task automatic test_straight();
        int starts[$];
        bit saw_mem, prev_req;
        int dec_rises, n;
        bit prev_dec;
        fill_halts();
        imem[0] = 8'h45;
        rnd_lat = 0; stray = 0; stale = 0; manual = 0;
        do_reset();
        saw_mem = 0; prev_req = 0; prev_dec = 0; dec_rises = 0; n = 0;
        run = 1'b1; cyc(); run = 1'b0;
        while (!halted && n < 40) begin
            if (imem_req && !prev_req) starts.push_back(n);
            if (dec_en && !prev_dec) dec_rises++;
            if (mem_req && !saw_mem) begin
                saw_mem = 1;
                tests++;
                if ({exec_addr, exec_srcdst, pc, alu_req, io_req} !== {6'd5, 1'b0, 6'd0, 2'b00}) begin
                    fails++;
                    $display("FAIL straight_dispatch: got addr=%0d sd=%b pc=%0d alu=%b io=%b expected addr=5 sd=0 pc=0 alu=0 io=0",
                             exec_addr, exec_srcdst, pc, alu_req, io_req);
                end
            end
            prev_req = imem_req; prev_dec = dec_en;
            cyc(); n++;
        end
        tests++;
        if ({halted, busy, err, pc} !== {3'b100, 6'd1}) begin
            fails++;
            $display("FAIL straight_halt: got halted=%b busy=%b err=%b pc=%0d expected 1 0 0 1", halted, busy, err, pc);
        end
        tests++;
        if (saw_mem !== 1'b1 || dec_rises != 1) begin
            fails++;
            $display("FAIL straight_decodes: got mem_seen=%b dec_en_rises=%0d expected 1 1", saw_mem, dec_rises);
        end
        tests++;
        if (starts.size() != 2 || starts[1] - starts[0] != 5) begin
            fails++;
            $display("FAIL straight_latency: got %0d fetch starts, gap %0d expected 2 starts, gap 5",
                     starts.size(), (starts.size() >= 2) ? starts[1] - starts[0] : -1);
        end
    endtask

    task automatic test_jump();
        for (int z = 1; z >= 0; z--) begin
            int starts[$];
            bit prev_req, saw_req;
            int n;
            logic [PC_W-1:0] exp_pc;
            fill_halts();
            imem[0] = 8'h0A;
            rnd_lat = 0; stray = 0; stale = 0; manual = 0;
            do_reset();
            zero_flag = z[0];
            exp_pc = z[0] ? 6'd10 : 6'd1;
            prev_req = 0; saw_req = 0; n = 0;
            run = 1'b1; cyc(); run = 1'b0;
            while (!halted && n < 40) begin
                if (imem_req && !prev_req) starts.push_back(n);
                if (mem_req || alu_req || io_req) saw_req = 1;
                prev_req = imem_req;
                cyc(); n++;
            end
            tests++;
            if ({halted, pc, saw_req} !== {1'b1, exp_pc, 1'b0}) begin
                fails++;
                $display("FAIL jump_z%0d: got halted=%b pc=%0d req_seen=%b expected 1 %0d 0", z, halted, pc, saw_req, exp_pc);
            end
            tests++;
            if (starts.size() != 2 || starts[1] - starts[0] != 4) begin
                fails++;
                $display("FAIL jump_latency_z%0d: got %0d fetch starts expected 2 with gap 4", z, starts.size());
            end
        end
    endtask

    task automatic test_wrap_stray();
        int n;
        fill_halts();
        imem[0]  = 8'h3F;
        imem[63] = 8'h80;
        rnd_lat = 0; stray = 0; stale = 0; manual = 1;
        zero_flag = 1'b1;
        do_reset();
        run = 1'b1; cyc(); run = 1'b0;
        n = 0;
        while (!alu_req && n < 30) begin cyc(); n++; end
        tests++;
        if ({alu_req, pc} !== {1'b1, 6'd63}) begin
            fails++;
            $display("FAIL wrap_enter: got alu_req=%b pc=%0d expected 1 63", alu_req, pc);
        end
        for (int i = 0; i < 2; i++) begin
            io_ack = 1'b1; mem_ack = 1'b1;
            cyc();
            tests++;
            if ({alu_req, mem_req, io_req, pc, halted} !== {3'b100, 6'd63, 1'b0}) begin
                fails++;
                $display("FAIL stray_ack_%0d: got alu=%b mem=%b io=%b pc=%0d halted=%b expected 1 0 0 63 0",
                         i, alu_req, mem_req, io_req, pc, halted);
            end
        end
        alu_ack = 1'b1;
        cyc();
        tests++;
        if ({alu_req, pc, imem_req, imem_addr} !== {1'b0, 6'd0, 1'b1, 6'd0}) begin
            fails++;
            $display("FAIL wrap_pc: got alu=%b pc=%0d imem_req=%b addr=%0d expected 0 0 1 0", alu_req, pc, imem_req, imem_addr);
        end
        manual = 0;
    endtask

    task automatic test_timeout();
        int n, k;
        bit held;
        fill_halts();
        imem[0] = 8'hC0;
        rnd_lat = 0; stray = 0; stale = 0; manual = 1;
        do_reset();
        run = 1'b1; cyc(); run = 1'b0;
        n = 0;
        while (!io_req && n < 20) begin cyc(); n++; end
        tests++;
        if (io_req !== 1'b1) begin
            fails++;
            $display("FAIL timeout_req: got io_req=%b expected 1", io_req);
        end
        k = 0; held = 1;
        while (!halted && k < 40) begin
            cyc(); k++;
            if (!halted && io_req !== 1'b1) held = 0;
        end
        tests++;
        if (k != TMO || !held) begin
            fails++;
            $display("FAIL timeout_cycles: got %0d cycles held=%b expected %0d held=1", k, held, TMO);
        end
        tests++;
        if ({io_req, err, halted, busy, pc} !== {4'b0110, 6'd0}) begin
            fails++;
            $display("FAIL timeout_state: got io=%b err=%b halted=%b busy=%b pc=%0d expected 0 1 1 0 0",
                     io_req, err, halted, busy, pc);
        end
        run = 1'b1; cyc(); run = 1'b0; cyc();
        tests++;
        if ({halted, busy, imem_req, err, pc} !== {4'b1001, 6'd0}) begin
            fails++;
            $display("FAIL halt_ignores_run: got halted=%b busy=%b imem_req=%b err=%b pc=%0d expected 1 0 0 1 0",
                     halted, busy, imem_req, err, pc);
        end
        rst = 1'b1; cyc(); rst = 1'b0;
        tests++;
        if (outs() !== 35'd0) begin
            fails++;
            $display("FAIL reset_clears_err: got %h expected 0", outs());
        end
        manual = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        fill_halts();
        imem[0] = 8'h80;
        rnd_lat = 0; stray = 0; stale = 0; manual = 1;
        do_reset();
        run = 1'b1; cyc(); run = 1'b0;
        n = 0;
        while (!alu_req && n < 20) begin cyc(); n++; end
        cyc(); cyc();
        tests++;
        if (alu_req !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre: got alu_req=%b expected 1", alu_req);
        end
        rst = 1'b1; alu_ack = 1'b1;
        cyc();
        tests++;
        if (outs() !== 35'd0) begin
            fails++;
            $display("FAIL midreset_outs: got %h expected 0", outs());
        end
        rst = 1'b0;
        cyc(); cyc(); cyc();
        tests++;
        if (outs() !== 35'd0) begin
            fails++;
            $display("FAIL midreset_idle: got %h expected 0", outs());
        end
        manual = 0;
    endtask

    // Random forward-only program; an instruction-level model predicts each
    // fetch address, each dispatch and the final halt pc.
    task automatic test_random(input bit lat, input bit str, input bit stl);
        logic [PC_W-1:0] mpc, exp_ipc, halt_pc;
        logic [2:0] exp_req, reqv, prev_reqv;
        logic [5:0] exp_addr;
        logic exp_sd, exp_pend, exp_halt;
        logic [7:0] w;
        int n;
        for (int i = 0; i < 64; i++) begin
            int t;
            if (i == 63 || $urandom_range(0, 15) == 0) w = 8'hFF;
            else begin
                t = int'($urandom_range(0, 3));
                if (t == 0) w = {2'b00, 6'($urandom_range(i + 1, 63))};
                else begin
                    w = {2'(t), 6'($urandom_range(0, 63))};
                    if (w == 8'hFF) w = 8'hFE;
                end
            end
            imem[i] = w;
        end
        rnd_lat = 0; stray = 0; stale = 0; manual = 0;
        do_reset();
        rnd_lat = lat; stray = str; stale = stl;
        mpc = '0; exp_pend = 0; exp_halt = 0; prev_reqv = '0;
        exp_req = '0; exp_addr = '0; exp_sd = 0; exp_ipc = '0; halt_pc = '0;
        run = 1'b1; cyc(); run = 1'b0;
        n = 0;
        while (!halted && n < 2000) begin
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL rnd_busy cycle %0d: got %b expected 1", n, busy);
            end
            reqv = {io_req, alu_req, mem_req};
            if (reqv != 3'b000 && prev_reqv == 3'b000) begin
                tests++;
                if ({reqv, exec_addr, exec_srcdst, pc, exp_pend} !== {exp_req, exp_addr, exp_sd, exp_ipc, 1'b1}) begin
                    fails++;
                    $display("FAIL rnd_dispatch: got req=%b addr=%0d sd=%b pc=%0d pend=%b expected req=%b addr=%0d sd=%b pc=%0d",
                             reqv, exec_addr, exec_srcdst, pc, exp_pend, exp_req, exp_addr, exp_sd, exp_ipc);
                end
                exp_pend = 0;
            end
            prev_reqv = reqv;
            if (imem_req && imem_ack) begin
                tests++;
                if ({imem_addr, exp_pend, exp_halt} !== {mpc, 2'b00}) begin
                    fails++;
                    $display("FAIL rnd_fetch: got addr=%0d expected addr=%0d (pending=%b halt=%b)", imem_addr, mpc, exp_pend, exp_halt);
                end
                w = imem[mpc];
                zero_flag = 1'($urandom_range(0, 1));
                if (w == 8'hFF) begin
                    exp_halt = 1; halt_pc = mpc;
                end else if (w[7:6] == 2'b00) begin
                    mpc = zero_flag ? w[5:0] : mpc + 1'b1;
                end else begin
                    exp_req  = 3'b001 << (w[7:6] - 2'd1);
                    exp_addr = w[5:0];
                    exp_sd   = w[5];
                    exp_ipc  = mpc;
                    exp_pend = 1;
                    mpc      = mpc + 1'b1;
                end
            end
            cyc(); n++;
        end
        tests++;
        if ({halted, exp_halt, pc, err, busy, dec_en, io_req, alu_req, mem_req} !== {2'b11, halt_pc, 6'b0}) begin
            fails++;
            $display("FAIL rnd_halt: got halted=%b model_halt=%b pc=%0d err=%b busy=%b expected 1 1 %0d 0 0 after %0d cycles",
                     halted, exp_halt, pc, err, busy, halt_pc, n);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; zero_flag = 1'b0;
        imem_ack = 1'b0; imem_data = 8'h00;
        dec_type = 2'b00; dec_srcdst = 1'b0; dec_addr = 6'd0; dec_ready = 1'b0;
        mem_ack = 1'b0; alu_ack = 1'b0; io_ack = 1'b0;
        rnd_lat = 0; stray = 0; stale = 0; manual = 0;
        fcnt = 0; mlat = 0; dcnt = 0; dtgt = 0; ecnt = 0; elat = 0;
        fill_halts();
        test_reset();
        test_straight();
        test_jump();
        test_wrap_stray();
        test_timeout();
        test_reset_mid();
        test_random(1'b0, 1'b0, 1'b0);
        test_random(1'b1, 1'b1, 1'b1);
        test_random(1'b1, 1'b0, 1'b1);
        test_random(1'b1, 1'b1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
